// File: rtl/cfg_frame_rx.sv
// Byte-wide configuration frame receiver: sync / address / length / payload / checksum.
// Emits one shadow-register write per payload byte, then a commit or error pulse per frame.
module cfg_frame_rx #(
    parameter int          ADDR_W    = 6,
    parameter int          MAX_LEN   = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [7:0]        cfg_wdata,
    output logic              commit,
    output logic              frame_err,
    output logic              busy,
    output logic [1:0]        err_code
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [LEN_W-1:0]   remain_q;
    logic [7:0]         chk_q;
    logic [TMO_W-1:0]   tmo_q;

    logic               in_ready_q;
    logic               cfg_we_q;
    logic [ADDR_W-1:0]  cfg_addr_q;
    logic [7:0]         cfg_wdata_q;
    logic               commit_q;
    logic               frame_err_q;
    logic               busy_q;
    logic [1:0]         err_code_q;

    logic               xfer;
    logic               in_frame;
    logic               tmo_hit;
    logic               timeout_ev;
    logic               len_ok;
    logic [7:0]         chk_d;

    assign xfer       = in_valid && in_ready_q;
    assign in_frame   = (state_q == S_ADDR) || (state_q == S_LEN) ||
                        (state_q == S_DATA) || (state_q == S_CHK);
    // The count equals the number of idle cycles already elapsed, so this
    // cycle is the TIMEOUT-th idle one; a transfer in it still wins.
    assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign timeout_ev = in_frame && !xfer && tmo_hit;
    assign len_ok     = (in_data != 8'd0) && (int'(in_data) <= MAX_LEN);
    assign chk_d      = chk_q ^ in_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (xfer && in_data == SYNC_BYTE) state_d = S_ADDR;
            S_ADDR: begin
                if (xfer)         state_d = S_LEN;
                else if (tmo_hit) state_d = S_RESP;
            end
            S_LEN: begin
                if (xfer)         state_d = len_ok ? S_DATA : S_RESP;
                else if (tmo_hit) state_d = S_RESP;
            end
            S_DATA: begin
                if (xfer) begin
                    if (remain_q == LEN_W'(1)) state_d = S_CHK;
                end else if (tmo_hit) begin
                    state_d = S_RESP;
                end
            end
            S_CHK:  if (xfer || tmo_hit) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_addr_q   <= '0;
            remain_q    <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            in_ready_q  <= 1'b0;
            cfg_we_q    <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != S_RESP);
            busy_q      <= (state_d != S_IDLE);
            cfg_we_q    <= 1'b0;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tmo_q       <= (in_frame && !xfer) ? tmo_q + 1'b1 : '0;

            if (timeout_ev) begin
                frame_err_q <= 1'b1;
                err_code_q  <= 2'd3;
            end

            case (state_q)
                S_ADDR: if (xfer) begin
                    wr_addr_q <= in_data[ADDR_W-1:0];
                    chk_q     <= in_data;
                end
                S_LEN: if (xfer) begin
                    if (len_ok) begin
                        chk_q    <= chk_d;
                        remain_q <= in_data[LEN_W-1:0];
                    end else begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= 2'd2;
                    end
                end
                S_DATA: if (xfer) begin
                    cfg_we_q    <= 1'b1;
                    cfg_addr_q  <= wr_addr_q;
                    cfg_wdata_q <= in_data;
                    wr_addr_q   <= wr_addr_q + 1'b1;
                    remain_q    <= remain_q - 1'b1;
                    chk_q       <= chk_d;
                end
                S_CHK: if (xfer) begin
                    if (in_data == chk_q) begin
                        commit_q   <= 1'b1;
                        err_code_q <= 2'd0;
                    end else begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign cfg_we    = cfg_we_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_wdata = cfg_wdata_q;
    assign commit    = commit_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_cfg_frame_rx.sv
// Directed bench for cfg_frame_rx: frames are sent byte by byte, writes and pulses
// are collected on the falling edge and compared with hand-computed expectations.
module tb_cfg_frame_rx;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [7:0]        cfg_wdata;
    logic              commit;
    logic              frame_err;
    logic              busy;
    logic [1:0]        err_code;

    int total = 0;
    int bad   = 0;
    int gap_max = 0;

    int commit_cnt = 0;
    int err_cnt    = 0;
    logic [13:0] wr_q[$];

    logic [7:0] fq[$];
    logic [7:0] dq[$];

    cfg_frame_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .commit    (commit),
        .frame_err (frame_err),
        .busy      (busy),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_we)    wr_q.push_back({cfg_addr, cfg_wdata});
        if (commit)    commit_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called and returns 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b);
        int g;
        int guard;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) check("ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Sends fq; expects writes dq at a0.. and either a commit or a frame_err with exp_code.
    task automatic frame(input string tag, input logic [ADDR_W-1:0] a0,
                         input logic exp_commit, input logic [1:0] exp_code);
        int c0, e0, w0;
        logic [ADDR_W-1:0] ea;
        c0 = commit_cnt;
        e0 = err_cnt;
        w0 = wr_q.size();
        foreach (fq[i]) send(fq[i]);
        check({tag, "_commit"}, {31'd0, commit}, {31'd0, exp_commit});
        check({tag, "_ferr"}, {31'd0, frame_err}, {31'd0, !exp_commit});
        check({tag, "_code"}, {30'd0, err_code}, {30'd0, exp_code});
        check({tag, "_busy_resp"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_ready_idle"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_ncommit"}, commit_cnt - c0, {31'd0, exp_commit});
        check({tag, "_nerr"}, err_cnt - e0, {31'd0, !exp_commit});
        check({tag, "_nwrites"}, wr_q.size() - w0, dq.size());
        foreach (dq[i]) begin
            ea = a0 + ADDR_W'(i);
            if (w0 + i < wr_q.size())
                check({tag, "_wr"}, {18'd0, wr_q[w0 + i]}, {18'd0, ea, dq[i]});
        end
        $display("frame %s: bytes=%0d writes=%0d commit=%0d err_code=%0d",
                 tag, fq.size(), wr_q.size() - w0, commit_cnt - c0, err_code);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, e0, n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we",    {31'd0, cfg_we}, 32'd0);
        check("rst_addr",  {26'd0, cfg_addr}, 32'd0);
        check("rst_wdata", {24'd0, cfg_wdata}, 32'd0);
        check("rst_commit",{31'd0, commit}, 32'd0);
        check("rst_ferr",  {31'd0, frame_err}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_code",  {30'd0, err_code}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("rel_ready_high", {31'd0, in_ready}, 32'd1);

        // Good frame with the single-cycle write latency checked directly.
        send(8'hA5); send(8'h04); send(8'h02);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        send(8'h11);
        check("lat_we",   {31'd0, cfg_we}, 32'd1);
        check("lat_addr", {26'd0, cfg_addr}, 32'd4);
        check("lat_data", {24'd0, cfg_wdata}, 32'h11);
        @(posedge clk); #1;
        check("gap_we_low", {31'd0, cfg_we}, 32'd0);
        send(8'h22); send(8'h35);
        check("good_commit", {31'd0, commit}, 32'd1);
        check("good_code", {30'd0, err_code}, 32'd0);
        check("resp_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("good_idle", {31'd0, busy}, 32'd0);

        fq = {8'hA5, 8'h04, 8'h02, 8'h11, 8'h22, 8'h35};
        dq = {8'h11, 8'h22};
        frame("good", 6'd4, 1'b1, 2'd0);

        fq = {8'hA5, 8'h04, 8'h02, 8'h11, 8'h22, 8'h34};
        frame("badchk", 6'd4, 1'b0, 2'd1);

        dq.delete();
        fq = {8'hA5, 8'h00, 8'h00};
        frame("len0", 6'd0, 1'b0, 2'd2);
        fq = {8'hA5, 8'h00, 8'h11};
        frame("len17", 6'd0, 1'b0, 2'd2);

        // Mid-frame reset while err_code still holds the length error.
        c0 = commit_cnt;
        e0 = err_cnt;
        send(8'hA5); send(8'h04); send(8'h02); send(8'h11);
        check("prerst_we", {31'd0, cfg_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we",    {31'd0, cfg_we}, 32'd0);
        check("midrst_addr",  {26'd0, cfg_addr}, 32'd0);
        check("midrst_wdata", {24'd0, cfg_wdata}, 32'd0);
        check("midrst_busy",  {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_code",  {30'd0, err_code}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_ncommit", commit_cnt - c0, 32'd0);
        check("midrst_nerr", err_cnt - e0, 32'd0);
        $display("frame midrst: reset after first data byte");

        fq = {8'hA5, 8'h04, 8'h02, 8'h11, 8'h22, 8'h35};
        dq = {8'h11, 8'h22};
        frame("postrst", 6'd4, 1'b1, 2'd0);

        fq = {8'hA5, 8'h3F, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hE1};
        dq = {8'hAA, 8'hBB, 8'hCC};
        frame("wrap", 6'd63, 1'b1, 2'd0);

        // Leading garbage, then a SYNC value used as payload data.
        fq = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h05, 8'h01, 8'hA5, 8'hA1};
        dq = {8'hA5};
        frame("garbage", 6'd5, 1'b1, 2'd0);

        // Maximum length: payload 00..0F xors to 0, and 10^10 = 0.
        fq = {8'hA5, 8'h10, 8'h10};
        dq.delete();
        for (int i = 0; i < 16; i++) begin
            fq.push_back(8'(i));
            dq.push_back(8'(i));
        end
        fq.push_back(8'h00);
        frame("maxlen", 6'd16, 1'b1, 2'd0);

        // Timeout: frame_err appears exactly 255 idle cycles after the last byte.
        c0 = commit_cnt;
        send(8'hA5); send(8'h01); send(8'h01);
        n = 0;
        while (!frame_err && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_cycles", n, 32'd255);
        check("tmo_code", {30'd0, err_code}, 32'd3);
        @(posedge clk); #1;
        check("tmo_idle", {31'd0, busy}, 32'd0);
        check("tmo_ncommit", commit_cnt - c0, 32'd0);
        $display("frame timeout: err after %0d idle cycles, err_code=%0d", n, err_code);

        // 254 idle cycles, then the next byte lands on the boundary cycle.
        c0 = commit_cnt;
        send(8'hA5); send(8'h01); send(8'h01);
        repeat (254) begin
            @(posedge clk); #1;
        end
        check("gap254_noerr", {31'd0, frame_err}, 32'd0);
        check("gap254_busy", {31'd0, busy}, 32'd1);
        send(8'h5A);
        check("gap254_we", {31'd0, cfg_we}, 32'd1);
        send(8'h5A);
        check("gap254_commit", {31'd0, commit}, 32'd1);
        check("gap254_code", {30'd0, err_code}, 32'd0);
        @(posedge clk); #1;
        check("gap254_ncommit", commit_cnt - c0, 32'd1);
        $display("frame gap254: commit=%0d", commit_cnt - c0);

        // Throttled delivery must give the same results as back-to-back.
        gap_max = 10;
        fq = {8'hA5, 8'h04, 8'h02, 8'h11, 8'h22, 8'h35};
        dq = {8'h11, 8'h22};
        frame("thr_good", 6'd4, 1'b1, 2'd0);
        fq = {8'hA5, 8'h04, 8'h02, 8'h11, 8'h22, 8'h34};
        frame("thr_bad", 6'd4, 1'b0, 2'd1);
        fq = {8'hA5, 8'h3F, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hE1};
        dq = {8'hAA, 8'hBB, 8'hCC};
        frame("thr_wrap", 6'd63, 1'b1, 2'd0);
        gap_max = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
